// File: rtl/rf_pkg.sv
// Shared register-file definitions: default geometry, the hardwired-zero index
// and address/data types reused by the hazard unit and decoder.
package rf_pkg;

   localparam int DEF_ADDR_WIDTH = 5;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_NUM_READ   = 2;
   localparam int ZERO_REG       = 0;

   typedef logic [DEF_ADDR_WIDTH-1:0] rf_addr_t;
   typedef logic [DEF_DATA_WIDTH-1:0] rf_data_t;

endpackage

// File: rtl/register_file_mp_if.sv
// Register-file access bundle: read ports, two write ports and the scoreboard
// set request. The datapath drives it as master; the register file is slave.
interface register_file_mp_if
   import rf_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int NUM_READ   = DEF_NUM_READ
);

   logic [NUM_READ*ADDR_WIDTH-1:0] RA;
   logic [NUM_READ*DATA_WIDTH-1:0] RD;
   logic [NUM_READ-1:0]            BUSY;
   logic                           WE0;
   logic                           WE1;
   logic [ADDR_WIDTH-1:0]          WA0;
   logic [ADDR_WIDTH-1:0]          WA1;
   logic [DATA_WIDTH-1:0]          WD0;
   logic [DATA_WIDTH-1:0]          WD1;
   logic                           SB_SET;
   logic [ADDR_WIDTH-1:0]          SB_ADDR;

   modport master (
      output RA, WE0, WE1, WA0, WA1, WD0, WD1, SB_SET, SB_ADDR,
      input  RD, BUSY
   );

   modport slave (
      input  RA, WE0, WE1, WA0, WA1, WD0, WD1, SB_SET, SB_ADDR,
      output RD, BUSY
   );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register pending bits for RAW hazard detection: set by an issued producer,
// cleared by its write-back, looked up per read port.
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int NUM_READ   = DEF_NUM_READ,
   parameter int BYPASS     = 1
) (
   input  logic                           CLK,
   input  logic                           RESET,
   input  logic [NUM_READ*ADDR_WIDTH-1:0] ra_i,
   input  logic                           we0_i,
   input  logic [ADDR_WIDTH-1:0]          wa0_i,
   input  logic                           we1_i,
   input  logic [ADDR_WIDTH-1:0]          wa1_i,
   input  logic                           sb_set_i,
   input  logic [ADDR_WIDTH-1:0]          sb_addr_i,
   output logic [NUM_READ-1:0]            busy_o
);

   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

   logic [DEPTH-1:0] pending_q;
   logic [DEPTH-1:0] pending_d;

   // NOTE: combinational blocks use blocking '=' and assign a default first, so no latch is inferred.
   always_comb begin
      pending_d = pending_q;
      if (we0_i) pending_d[wa0_i] = 1'b0;
      if (we1_i) pending_d[wa1_i] = 1'b0;
      // Set applied last: a newly issued producer outranks the retiring one.
      if (sb_set_i && sb_addr_i != ZERO_ADDR) pending_d[sb_addr_i] = 1'b1;
      pending_d[ZERO_REG] = 1'b0;
   end

   // NOTE: sequential state is updated only with non-blocking '<=' so every flop samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (RESET) pending_q <= '0;
      else       pending_q <= pending_d;
   end

   for (genvar k = 0; k < NUM_READ; k++) begin : g_busy
      logic [ADDR_WIDTH-1:0] ra_k;
      logic                  wr_hit;

      assign ra_k   = ra_i[k*ADDR_WIDTH +: ADDR_WIDTH];
      assign wr_hit = (we0_i && wa0_i == ra_k) || (we1_i && wa1_i == ra_k);
      assign busy_o[k] = pending_q[ra_k] && !((BYPASS != 0) && wr_hit);
   end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port architectural register file: NUM_READ combinational reads, two
// synchronous writes (port 1 wins), hardwired-zero x0, optional write bypass.
module register_file_mp
   import rf_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int NUM_READ   = DEF_NUM_READ,
   parameter int BYPASS     = 1
) (
   input  logic               CLK,
   input  logic               RESET,
   register_file_mp_if.slave  rf
);

   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

   typedef struct packed {
      logic                  en;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
   } wr_port_t;

   wr_port_t wr0;
   wr_port_t wr1;

   // en already excludes x0, so later logic never needs to special-case it.
   assign wr0 = '{en: rf.WE0 && rf.WA0 != ZERO_ADDR, addr: rf.WA0, data: rf.WD0};
   assign wr1 = '{en: rf.WE1 && rf.WA1 != ZERO_ADDR, addr: rf.WA1, data: rf.WD1};

   logic [DATA_WIDTH-1:0] regs_q [1:DEPTH-1];
   logic [DATA_WIDTH-1:0] regs_d [1:DEPTH-1];

   always_comb begin
      regs_d = regs_q;
      if (wr0.en) regs_d[wr0.addr] = wr0.data;
      if (wr1.en) regs_d[wr1.addr] = wr1.data;
   end

   // NOTE: this array is built from flops, not a RAM macro, so clearing every entry on reset is legal.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int i = 1; i < DEPTH; i++) regs_q[i] <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   for (genvar k = 0; k < NUM_READ; k++) begin : g_read
      logic [ADDR_WIDTH-1:0] ra_k;
      logic [DATA_WIDTH-1:0] rd_k;

      assign ra_k = rf.RA[k*ADDR_WIDTH +: ADDR_WIDTH];

      always_comb begin
         rd_k = '0;
         if (ra_k != ZERO_ADDR) begin
            rd_k = regs_q[ra_k];
            if (BYPASS != 0) begin
               if (wr1.en && wr1.addr == ra_k)      rd_k = wr1.data;
               else if (wr0.en && wr0.addr == ra_k) rd_k = wr0.data;
            end
         end
      end

      assign rf.RD[k*DATA_WIDTH +: DATA_WIDTH] = rd_k;
   end

   rf_scoreboard #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_READ   (NUM_READ),
      .BYPASS     (BYPASS)
   ) u_scoreboard (
      .CLK       (CLK),
      .RESET     (RESET),
      .ra_i      (rf.RA),
      .we0_i     (rf.WE0),
      .wa0_i     (rf.WA0),
      .we1_i     (rf.WE1),
      .wa1_i     (rf.WA1),
      .sb_set_i  (rf.SB_SET),
      .sb_addr_i (rf.SB_ADDR),
      .busy_o    (rf.BUSY)
   );

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: a bypassing and a non-bypassing instance share one
// stimulus stream; a reference model feeds an expected-value queue per cycle.
module tb_register_file_mp;
   import rf_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [2*DEF_ADDR_WIDTH-1:0] ra;
   logic                        we0, we1, sb_set;
   rf_addr_t                    wa0, wa1, sb_addr;
   rf_data_t                    wd0, wd1;

   register_file_mp_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_READ(2)) if_b ();
   register_file_mp_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_READ(2)) if_n ();

   assign if_b.RA = ra;   assign if_n.RA = ra;
   assign if_b.WE0 = we0; assign if_n.WE0 = we0;
   assign if_b.WE1 = we1; assign if_n.WE1 = we1;
   assign if_b.WA0 = wa0; assign if_n.WA0 = wa0;
   assign if_b.WA1 = wa1; assign if_n.WA1 = wa1;
   assign if_b.WD0 = wd0; assign if_n.WD0 = wd0;
   assign if_b.WD1 = wd1; assign if_n.WD1 = wd1;
   assign if_b.SB_SET = sb_set;   assign if_n.SB_SET = sb_set;
   assign if_b.SB_ADDR = sb_addr; assign if_n.SB_ADDR = sb_addr;

   register_file_mp #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_READ(2), .BYPASS(1)) u_dut_byp (
      .CLK(clk), .RESET(rst), .rf(if_b)
   );
   register_file_mp #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_READ(2), .BYPASS(0)) u_dut_nob (
      .CLK(clk), .RESET(rst), .rf(if_n)
   );

   // Reference model of architectural state.
   rf_data_t m_reg [32];
   bit       m_pend [32];

   typedef struct {
      string       name;
      logic [63:0] rd_b;
      logic [63:0] rd_n;
      logic [1:0]  busy_b;
      logic [1:0]  busy_n;
   } exp_t;
   exp_t exp_q [$];

   int checks = 0;
   int failures = 0;

   function automatic rf_data_t exp_rd(input bit byp, input rf_addr_t a);
      if (a == 0) return '0;
      if (byp && we1 && wa1 == a) return wd1;
      if (byp && we0 && wa0 == a) return wd0;
      return m_reg[a];
   endfunction

   function automatic logic exp_busy(input bit byp, input rf_addr_t a);
      if (a == 0) return 1'b0;
      if (byp && ((we0 && wa0 == a) || (we1 && wa1 == a))) return 1'b0;
      return m_pend[a];
   endfunction

   task automatic model_edge();
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            m_reg[i] = '0;
            m_pend[i] = 1'b0;
         end
      end else begin
         if (we0 && wa0 != 0) m_reg[wa0] = wd0;
         if (we1 && wa1 != 0) m_reg[wa1] = wd1;
         if (we0) m_pend[wa0] = 1'b0;
         if (we1) m_pend[wa1] = 1'b0;
         if (sb_set && sb_addr != 0) m_pend[sb_addr] = 1'b1;
      end
   endtask

   task automatic idle_inputs();
      we0 = 0; we1 = 0; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
      sb_set = 0; sb_addr = '0;
   endtask

   // Settle combinational outputs, push the model's prediction, pop and compare.
   task automatic sample(input string name);
      exp_t e;
      exp_t got;
      #2;
      e.name   = name;
      e.rd_b   = {exp_rd(1, ra[9:5]), exp_rd(1, ra[4:0])};
      e.rd_n   = {exp_rd(0, ra[9:5]), exp_rd(0, ra[4:0])};
      e.busy_b = {exp_busy(1, ra[9:5]), exp_busy(1, ra[4:0])};
      e.busy_n = {exp_busy(0, ra[9:5]), exp_busy(0, ra[4:0])};
      exp_q.push_back(e);
      got = exp_q.pop_front();
      checks += 4;
      if (if_b.RD !== got.rd_b) begin
         failures++;
         $display("FAIL %s rd_byp ra=%h got=%h exp=%h", got.name, ra, if_b.RD, got.rd_b);
      end
      if (if_n.RD !== got.rd_n) begin
         failures++;
         $display("FAIL %s rd_nob ra=%h got=%h exp=%h", got.name, ra, if_n.RD, got.rd_n);
      end
      if (if_b.BUSY !== got.busy_b) begin
         failures++;
         $display("FAIL %s busy_byp ra=%h got=%b exp=%b", got.name, ra, if_b.BUSY, got.busy_b);
      end
      if (if_n.BUSY !== got.busy_n) begin
         failures++;
         $display("FAIL %s busy_nob ra=%h got=%b exp=%b", got.name, ra, if_n.BUSY, got.busy_n);
      end
   endtask

   task automatic advance();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic direct(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      ra = '0;
      rst = 1;
      advance();
      rst = 0;
      for (int i = 0; i < 32; i++) begin
         ra = {5'(31 - i), 5'(i)};
         sample("reset_read");
         direct("reset_rd0", if_n.RD[31:0], 32'h0);
         direct("reset_busy", {30'h0, if_b.BUSY}, 32'h0);
         advance();
      end
   endtask

   task automatic test_write_all();
      for (int i = 0; i < 32; i++) begin
         idle_inputs();
         we0 = 1; wa0 = 5'(i); wd0 = 32'(i);
         ra = {5'($urandom_range(31)), 5'(i)};
         sample("write_all");
         advance();
      end
      idle_inputs();
      for (int i = 0; i < 32; i++) begin
         ra = {5'($urandom_range(31)), 5'($urandom_range(31))};
         sample("read_back");
         advance();
      end
      ra = {5'd17, 5'd0};
      sample("read_x0");
      direct("x0_reads_zero", if_b.RD[31:0], 32'h0);
      direct("r17_reads_17", if_n.RD[63:32], 32'd17);
      advance();
   endtask

   task automatic test_collision();
      idle_inputs();
      we0 = 1; wa0 = 5'd5; wd0 = 32'hAAAA;
      we1 = 1; wa1 = 5'd5; wd1 = 32'h5555;
      ra = {5'd6, 5'd5};
      sample("collision");
      direct("collision_bypass", if_b.RD[31:0], 32'h5555);
      direct("collision_nob_old", if_n.RD[31:0], 32'd5);
      advance();
      idle_inputs();
      sample("collision_after");
      direct("collision_stored", if_n.RD[31:0], 32'h5555);
      advance();
   endtask

   task automatic test_no_bypass();
      idle_inputs();
      we0 = 1; wa0 = 5'd7; wd0 = 32'h1234;
      ra = {5'd0, 5'd7};
      sample("nob_same_cycle");
      direct("nob_old_value", if_n.RD[31:0], 32'd7);
      direct("byp_new_value", if_b.RD[31:0], 32'h1234);
      advance();
      idle_inputs();
      sample("nob_next_cycle");
      direct("nob_new_value", if_n.RD[31:0], 32'h1234);
      advance();
   endtask

   task automatic test_scoreboard();
      idle_inputs();
      ra = {5'd9, 5'd9};
      sb_set = 1; sb_addr = 5'd9;
      sample("sb_set_cycle");
      direct("sb_not_yet", {30'h0, if_n.BUSY}, 32'h0);
      advance();
      idle_inputs();
      sample("sb_visible");
      direct("sb_busy_set", {30'h0, if_n.BUSY}, 32'h3);
      advance();
      we0 = 1; wa0 = 5'd9; wd0 = 32'h99;
      sample("sb_clear_cycle");
      direct("sb_byp_clear_now", {30'h0, if_b.BUSY}, 32'h0);
      direct("sb_nob_still_busy", {30'h0, if_n.BUSY}, 32'h3);
      advance();
      idle_inputs();
      sample("sb_cleared");
      direct("sb_cleared_nob", {30'h0, if_n.BUSY}, 32'h0);
      advance();
      we0 = 1; wa0 = 5'd9; wd0 = 32'h9A;
      sb_set = 1; sb_addr = 5'd9;
      sample("sb_set_and_clear");
      advance();
      idle_inputs();
      sample("sb_set_wins");
      direct("sb_set_wins_busy", {30'h0, if_b.BUSY}, 32'h3);
      advance();
      ra = {5'd9, 5'd0};
      sb_set = 1; sb_addr = 5'd0;
      sample("sb_x0_cycle");
      advance();
      idle_inputs();
      sample("sb_x0_ignored");
      direct("sb_x0_busy", {30'h0, if_n.BUSY}, 32'h2);
      advance();
   endtask

   task automatic test_reset_mid();
      idle_inputs();
      rst = 1;
      we0 = 1; wa0 = 5'd3; wd0 = 32'hFF;
      sb_set = 1; sb_addr = 5'd3;
      ra = {5'd9, 5'd3};
      advance();
      rst = 0;
      idle_inputs();
      sample("reset_mid");
      direct("reset_mid_r3", if_n.RD[31:0], 32'h0);
      direct("reset_mid_busy", {30'h0, if_n.BUSY}, 32'h0);
      advance();
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 300; n++) begin
         we0 = 1'($urandom); wa0 = 5'($urandom); wd0 = $urandom;
         we1 = 1'($urandom); wa1 = ($urandom_range(3) == 0) ? wa0 : 5'($urandom);
         wd1 = $urandom;
         sb_set = 1'($urandom); sb_addr = ($urandom_range(3) == 0) ? wa0 : 5'($urandom);
         ra = {(($urandom_range(2) == 0) ? wa1 : 5'($urandom)),
               (($urandom_range(2) == 0) ? sb_addr : 5'($urandom))};
         sample("random");
         advance();
      end
      idle_inputs();
   endtask

   initial begin
      rst = 1;
      idle_inputs();
      ra = '0;
      for (int i = 0; i < 32; i++) begin
         m_reg[i] = '0;
         m_pend[i] = 1'b0;
      end
      @(negedge clk);
      test_reset();
      test_write_all();
      test_collision();
      test_no_bypass();
      test_scoreboard();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/register_file_mp.md
# register_file_mp

Parametrised multi-port register file for the single-cycle and upcoming pipelined RISC-V datapath, sitting in the architectural state registers alongside the PC. It generalises the current two-read, one-write file:
- NUM_READ asynchronous read ports.
- Two synchronous write ports.
- Hardwired-zero register 0.
- Optional write-to-read bypass.
- Per-register pending scoreboard, so a pipelined core can detect RAW hazards on in-flight destinations.

## Interface
Parameters:
- ADDR_WIDTH, 5, register address width; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 32, register width in bits.
- NUM_READ, 2, number of read ports (1..4).
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return stored value.

Ports:
- CLK  input  1  clock, all state updates on rising edge.
- RESET  input  1  synchronous, active-high; clears all registers and pending bits.
- RA  input  NUM_READ*ADDR_WIDTH  read addresses; port k = RA[k*ADDR_WIDTH +: ADDR_WIDTH].
- RD  output  NUM_READ*DATA_WIDTH  read data, same packing.
- BUSY  output  NUM_READ  port k's register has a pending (uncommitted) write.
- WE0, WE1  input  1 each  write enables.
- WA0, WA1  input  ADDR_WIDTH each  write addresses.
- WD0, WD1  input  DATA_WIDTH each  write data.
- SB_SET  input  1  mark register SB_ADDR pending.
- SB_ADDR  input  ADDR_WIDTH  scoreboard set address.

## Operation
- Storage:
  - 2**ADDR_WIDTH registers.
  - Register 0 is not stored: reads 0, ignores writes and SB_SET, BUSY always 0.
- Write:
  - At the rising edge, if WEn and WAn != 0, reg[WAn] <= WDn.
  - Both ports on the same address: port 1 wins.
- Read, combinational:
  - RD[k] = reg[RA[k]], subject to the bypass rules below.
  - BYPASS=1 and an enabled write to RA[k] (nonzero) this cycle: RD[k] = that write's data, WD1 if both ports match.
  - BYPASS=0: old value until the edge.
- Scoreboard:
  - pending[] is one bit per register.
  - At the edge, a write (WEn) to address a clears pending[a].
  - SB_SET sets pending[SB_ADDR].
  - Set and clear to the same address in the same cycle: set wins, because a new producer is issued.
  - Set to address 0 is ignored.
- BUSY[k] = pending[RA[k]], registered state only; no bypass of SB_SET.
  - With BYPASS=1, a write to RA[k] in the current cycle forces BUSY[k]=0, since data is available via bypass.
- Reset:
  - While RESET=1 at an edge: all registers <= 0 and all pending <= 0.
  - Writes and SB_SET in that cycle are discarded.
  - Applies mid-operation with no drain.

## Timing
- Read latency 0, combinational from RA, register state and, if BYPASS, WE/WA/WD.
- Write latency 1 edge. With BYPASS=0, data is visible on RD in the cycle after WE.
- Scoreboard latency:
  - SB_SET visible on BUSY the cycle after.
  - Clear by write is visible the cycle after, or the same cycle with BYPASS=1.
- Reset values, in the cycle after a RESET edge:
  - RD = 0 for all ports.
  - BUSY = 0 for all ports.
- No handshake; every port is accepted every cycle.

## Structure
- Shared package rf_pkg:
  - default ADDR_WIDTH/DATA_WIDTH constants.
  - ZERO_REG = 0 constant.
  - address/data typedefs for reuse by hazard unit and decoder.
- Sub-module rf_scoreboard, containing:
  - the pending bit vector.
  - set/clear priority logic.
  - per-port BUSY lookup.
- Top level holds the storage array, write priority, bypass muxes and the read-port generate loop.

## Test plan
- Reset then read all 32 addresses on both ports -> RD=0 and BUSY=0 everywhere.
- Write i to reg i for i=0..31 via WE0, then read with random RA -> RD=i, except reg 0 which reads 0.
- Same-cycle collision: WE0 WA0=5 WD0=0xAAAA, WE1 WA1=5 WD1=0x5555 -> reg5=0x5555. With BYPASS=1, RA=5 in that cycle shows 0x5555.
- BYPASS=0: write 0x1234 to reg 7 and read RA=7 in the same cycle -> old value, then 0x1234 after the edge.
- Scoreboard sequence:
  - SB_SET on reg 9 -> BUSY=1 next cycle.
  - WE0 to reg 9 -> BUSY clears.
  - Simultaneous SB_SET and WE on reg 9 -> stays BUSY=1.
  - SB_SET on reg 0 -> BUSY remains 0.
- RESET asserted with WE0 to reg 3 = 0xFF and SB_SET reg 3 -> next cycle reg3 reads 0 and BUSY=0.
